mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Parametrised next-generation multicycle main FSM for the ARM controller.
- Sequences fetch, decode, memory, ALU and branch with the existing datapath mux encodings.
- Adds a generic start/done handshake to NUM_XU variable-latency execution units (multiplier, FPU, ...), 64-bit two-beat write-back, and a watchdog timeout with fault reporting.
- Sits inside decode; its strobes feed condlogic unchanged.

Parameters:
NUM_XU, 2, number of variable-latency execution units (1..8)
XU_IDW, 1, width of unit index; must be >= clog2(NUM_XU), min 1
FPU_ID, 1, unit index whose results write the FPU file (FpuW) instead of RegW
TIMEOUT, 255, max XWAIT cycles before abort (1..2^TMR_W-1)
TMR_W, 8, watchdog counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]; Funct[5]=I, Funct[0]=L/S
xu_op  in  1  decoder flags instruction as execution-unit op (valid with Op=00)
xu_id  in  XU_IDW  target unit index
xu_wide  in  1  unit returns 64-bit result (UMULL/SMULL)
cond_ex  in  1  condition check result for current instruction
xu_done  in  NUM_XU  per-unit done pulse
IRWrite, NextPC, RegW, MemW, FpuW, Branch, ALUOp  out  1  datapath strobes
AdrSrc  out  1  0=PC, 1=ALU result
ALUSrcA  out  2  00=Rn, 01=PC, 10=ALUOut
ALUSrcB  out  2  00=Rm, 01=ExtImm, 10=const 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=XU result
Src_64b  out  1  selects high result word / second destination
xu_start  out  NUM_XU  one-hot one-cycle start pulse
xu_abort  out  1  one-cycle abort to selected unit on timeout
fault  out  1  one-cycle fault pulse
fault_code  out  2  00 none, 01 illegal Op, 10 XU timeout, 11 bad xu_id

Behaviour:
- While reset=0: state=FETCH; every output driven 0. First FETCH outputs appear in the cycle after reset deasserts. Reset mid-XWAIT abandons the op and emits no abort.
- Moore outputs, one state per cycle. Defaults are 0. Only the fields listed per state differ from default.
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - XSTART: xu_start[id_q]=1.
  - XWAIT: nothing asserted.
  - XWB: ResultSrc=11, plus RegW=1, or FpuW=1 if id_q==FPU_ID.
  - XWB_HI: as XWB plus Src_64b=1.
  - FAULT: fault=1, fault_code=code_q.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR. Op=10→BRANCH. Op=11→FAULT(01).
  - DECODE, Op=00 with xu_op=1:
    - xu_id>=NUM_XU→FAULT(11).
    - cond_ex=0→FETCH; no start issued.
    - else→XSTART, latching id_q=xu_id and wide_q=xu_wide.
  - DECODE, Op=00 with xu_op=0: Funct[5]=0→EXECUTER, else→EXECUTEI.
  - MEMADR: Funct[0]=1→MEMREAD, else→MEMWRITE.
  - MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH. BRANCH→FETCH.
  - XSTART: xu_done[id_q]=1 (zero-wait unit)→XWB, else→XWAIT.
  - XWAIT: xu_done[id_q]→XWB; else timer==TIMEOUT→FAULT(10) with xu_abort=1 in that XWAIT cycle; else stay.
  - XWB: wide_q→XWB_HI, else→FETCH. XWB_HI→FETCH.
  - FAULT→FETCH.
- Watchdog:
  - Cleared in XSTART; increments each XWAIT cycle; saturates, never wraps.
  - Done and timeout in the same cycle: done wins.
- xu_done bits of non-selected units are ignored in every state. xu_done outside XSTART/XWAIT is ignored.
- Any undefined state encoding→FETCH on the next clock.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (15 states)
  - ALUSrcA/ALUSrcB/ResultSrc encodings
  - fault_code constants
- Sub-module mc_xu_timer: TMR_W saturating counter with clr/inc inputs and hit=(count==TIMEOUT) output.

Test Plan:
- Reset pulse low mid-XWAIT, release → all outputs 0 during reset; FETCH outputs (IRWrite=1, NextPC=1) in first cycle after release; no xu_abort.
- LDR (Op=01, Funct[0]=1) → FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegW=1 only in MEMWB with ResultSrc=01. STR (Funct[0]=0) → MemW=1 one cycle.
- UMULL (xu_op=1, xu_id=0, xu_wide=1), done after 5 XWAIT cycles → xu_start=2'b01 once; XWB then XWB_HI (Src_64b=1); RegW=1 both cycles; FpuW=0.
- FPU op xu_id=1, xu_done[1] asserted during XSTART, xu_done[0] toggling → XSTART→XWB directly; FpuW=1, RegW=0; xu_done[0] ignored.
- TIMEOUT=3, done never arrives → 3 XWAIT cycles, xu_abort=1 on the 3rd; FAULT with fault_code=10; then FETCH. Variant: done on the 3rd XWAIT cycle → XWB, no abort.
- Op=11 → FAULT with code 01. xu_op with cond_ex=0 → DECODE→FETCH, xu_start never pulses. xu_id=2 with NUM_XU=2 → FAULT with code 11.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main controller.
// Mux select values match the existing datapath wiring.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_XSTART   = 4'd10,
        S_XWAIT    = 4'd11,
        S_XWB      = 4'd12,
        S_XWB_HI   = 4'd13,
        S_FAULT    = 4'd14
    } state_t;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_ILL    = 2'b11;

    localparam logic [1:0] SRCA_RN     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RM     = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_XU        = 2'b11;

    localparam logic [1:0] FC_NONE       = 2'b00;
    localparam logic [1:0] FC_ILLEGAL_OP = 2'b01;
    localparam logic [1:0] FC_XU_TIMEOUT = 2'b10;
    localparam logic [1:0] FC_BAD_XU_ID  = 2'b11;

endpackage

// File: rtl/mc_ctrl_fsm_timer.sv
// Saturating watchdog for execution-unit waits.
// Tracks how many wait cycles have elapsed, counting the current one.
module mc_xu_timer #(
    parameter int TMR_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    logic [TMR_W-1:0] count_q;

    // clr is issued in the cycle before the first wait cycle, so it loads 1:
    // the count then equals the index of the wait cycle in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= TMR_W'(1);
        end else if (inc && (count_q != {TMR_W{1'b1}})) begin
            count_q <= count_q + TMR_W'(1);
        end
    end

    assign hit = (count_q == TMR_W'(TIMEOUT));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main FSM: fetch/decode/memory/ALU/branch sequencing plus a
// start/done handshake to variable-latency execution units with a watchdog.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int NUM_XU  = 2,
    parameter int XU_IDW  = 1,
    parameter int FPU_ID  = 1,
    parameter int TIMEOUT = 255,
    parameter int TMR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic              xu_op,
    input  logic [XU_IDW-1:0] xu_id,
    input  logic              xu_wide,
    input  logic              cond_ex,
    input  logic [NUM_XU-1:0] xu_done,
    output logic              IRWrite,
    output logic              NextPC,
    output logic              RegW,
    output logic              MemW,
    output logic              FpuW,
    output logic              Branch,
    output logic              ALUOp,
    output logic              AdrSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic              Src_64b,
    output logic [NUM_XU-1:0] xu_start,
    output logic              xu_abort,
    output logic              fault,
    output logic [1:0]        fault_code
);

    state_t            state_q, state_d;
    logic [XU_IDW-1:0] id_q, id_d;
    logic              wide_q, wide_d;
    logic [1:0]        code_q, code_d;
    logic [NUM_XU-1:0] id_onehot;
    logic              done_sel;
    logic              id_bad;
    logic              tmr_hit;
    logic              funct_unused;

    // Only the latched unit's done bit is ever looked at.
    assign id_onehot    = NUM_XU'(1) << id_q;
    assign done_sel     = |(xu_done & id_onehot);
    assign id_bad       = 32'(xu_id) >= 32'(NUM_XU);
    assign funct_unused = ^Funct[4:1];

    mc_xu_timer #(
        .TMR_W   (TMR_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == S_XSTART),
        .inc   (state_q == S_XWAIT),
        .hit   (tmr_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            id_q    <= '0;
            wide_q  <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            wide_q  <= wide_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        wide_d  = wide_q;
        code_d  = code_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:    state_d = S_MEMADR;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_ILL: begin
                        state_d = S_FAULT;
                        code_d  = FC_ILLEGAL_OP;
                    end
                    default: begin
                        if (xu_op) begin
                            if (id_bad) begin
                                state_d = S_FAULT;
                                code_d  = FC_BAD_XU_ID;
                            end else if (!cond_ex) begin
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_XSTART;
                                id_d    = xu_id;
                                wide_d  = xu_wide;
                            end
                        end else if (Funct[5]) begin
                            state_d = S_EXECUTEI;
                        end else begin
                            state_d = S_EXECUTER;
                        end
                    end
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_XSTART:   state_d = done_sel ? S_XWB : S_XWAIT;
            S_XWAIT: begin
                if (done_sel) begin
                    state_d = S_XWB;
                end else if (tmr_hit) begin
                    state_d = S_FAULT;
                    code_d  = FC_XU_TIMEOUT;
                end
            end
            S_XWB:      state_d = wide_q ? S_XWB_HI : S_FETCH;
            S_XWB_HI:   state_d = S_FETCH;
            S_FAULT:    state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held, even though the state is FETCH.
    always_comb begin
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        FpuW       = 1'b0;
        Branch     = 1'b0;
        ALUOp      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_RN;
        ALUSrcB    = SRCB_RM;
        ResultSrc  = RES_ALUOUT;
        Src_64b    = 1'b0;
        xu_start   = '0;
        xu_abort   = 1'b0;
        fault      = 1'b0;
        fault_code = FC_NONE;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    NextPC    = 1'b1;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                S_DECODE: begin
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                S_MEMADR:   ALUSrcB = SRCB_EXTIMM;
                S_MEMREAD:  AdrSrc  = 1'b1;
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegW      = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                S_EXECUTER: ALUOp = 1'b1;
                S_EXECUTEI: begin
                    ALUSrcB = SRCB_EXTIMM;
                    ALUOp   = 1'b1;
                end
                S_ALUWB:    RegW = 1'b1;
                S_BRANCH: begin
                    ALUSrcB   = SRCB_EXTIMM;
                    ResultSrc = RES_ALURESULT;
                    Branch    = 1'b1;
                end
                S_XSTART:   xu_start = id_onehot;
                S_XWAIT:    xu_abort = !done_sel && tmr_hit;
                S_XWB, S_XWB_HI: begin
                    ResultSrc = RES_XU;
                    Src_64b   = (state_q == S_XWB_HI);
                    if (id_q == XU_IDW'(FPU_ID)) begin
                        FpuW = 1'b1;
                    end else begin
                        RegW = 1'b1;
                    end
                end
                S_FAULT: begin
                    fault      = 1'b1;
                    fault_code = code_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: two instances share stimulus, one with a
// long watchdog (TIMEOUT=8) and one with a short one (TIMEOUT=3).
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       xu_op;
    logic [1:0] xu_id;
    logic       xu_wide;
    logic       cond_ex;
    logic [1:0] xu_done;

    logic a_irw, a_npc, a_regw, a_memw, a_fpuw, a_br, a_aluop, a_adr, a_s64, a_abort, a_fault;
    logic [1:0] a_sa, a_sb, a_rs, a_xs, a_fc;
    logic b_irw, b_npc, b_regw, b_memw, b_fpuw, b_br, b_aluop, b_adr, b_s64, b_abort, b_fault;
    logic [1:0] b_sa, b_sb, b_rs, b_xs, b_fc;

    logic [20:0] vec_a, vec_b;

    int checks = 0;
    int errors = 0;

    // Field order: irw npc regw memw fpuw branch aluop adrsrc | srca srcb res | s64 start abort fault code
    localparam logic [20:0] E_ZERO      = '0;
    localparam logic [20:0] E_FETCH     = {8'b1100_0000, 2'b01, 2'b10, 2'b10, 7'b0};
    localparam logic [20:0] E_DECODE    = {8'b0000_0000, 2'b01, 2'b10, 2'b10, 7'b0};
    localparam logic [20:0] E_MEMADR    = {8'b0000_0000, 2'b00, 2'b01, 2'b00, 7'b0};
    localparam logic [20:0] E_MEMREAD   = {8'b0000_0001, 6'b0, 7'b0};
    localparam logic [20:0] E_MEMWB     = {8'b0010_0000, 2'b00, 2'b00, 2'b01, 7'b0};
    localparam logic [20:0] E_MEMWRITE  = {8'b0001_0001, 6'b0, 7'b0};
    localparam logic [20:0] E_EXECR     = {8'b0000_0010, 6'b0, 7'b0};
    localparam logic [20:0] E_EXECI     = {8'b0000_0010, 2'b00, 2'b01, 2'b00, 7'b0};
    localparam logic [20:0] E_ALUWB     = {8'b0010_0000, 6'b0, 7'b0};
    localparam logic [20:0] E_BRANCH    = {8'b0000_0100, 2'b00, 2'b01, 2'b10, 7'b0};
    localparam logic [20:0] E_XSTART0   = {14'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
    localparam logic [20:0] E_XSTART1   = {14'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00};
    localparam logic [20:0] E_XWAIT     = '0;
    localparam logic [20:0] E_XABORT    = {14'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00};
    localparam logic [20:0] E_XWB_REG   = {8'b0010_0000, 2'b00, 2'b00, 2'b11, 7'b0};
    localparam logic [20:0] E_XWB_FPU   = {8'b0000_1000, 2'b00, 2'b00, 2'b11, 7'b0};
    localparam logic [20:0] E_XWBHI_REG = {8'b0010_0000, 2'b00, 2'b00, 2'b11, 1'b1, 6'b0};
    localparam logic [20:0] E_FAULT_ILL = {14'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01};
    localparam logic [20:0] E_FAULT_TMO = {14'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10};
    localparam logic [20:0] E_FAULT_ID  = {14'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11};

    always #5 clk = ~clk;

    mc_ctrl_fsm #(
        .NUM_XU(2), .XU_IDW(2), .FPU_ID(1), .TIMEOUT(8), .TMR_W(8)
    ) dut_a (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .xu_op(xu_op),
        .xu_id(xu_id), .xu_wide(xu_wide), .cond_ex(cond_ex), .xu_done(xu_done),
        .IRWrite(a_irw), .NextPC(a_npc), .RegW(a_regw), .MemW(a_memw),
        .FpuW(a_fpuw), .Branch(a_br), .ALUOp(a_aluop), .AdrSrc(a_adr),
        .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ResultSrc(a_rs), .Src_64b(a_s64),
        .xu_start(a_xs), .xu_abort(a_abort), .fault(a_fault), .fault_code(a_fc)
    );

    mc_ctrl_fsm #(
        .NUM_XU(2), .XU_IDW(2), .FPU_ID(1), .TIMEOUT(3), .TMR_W(8)
    ) dut_b (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .xu_op(xu_op),
        .xu_id(xu_id), .xu_wide(xu_wide), .cond_ex(cond_ex), .xu_done(xu_done),
        .IRWrite(b_irw), .NextPC(b_npc), .RegW(b_regw), .MemW(b_memw),
        .FpuW(b_fpuw), .Branch(b_br), .ALUOp(b_aluop), .AdrSrc(b_adr),
        .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ResultSrc(b_rs), .Src_64b(b_s64),
        .xu_start(b_xs), .xu_abort(b_abort), .fault(b_fault), .fault_code(b_fc)
    );

    assign vec_a = {a_irw, a_npc, a_regw, a_memw, a_fpuw, a_br, a_aluop, a_adr,
                    a_sa, a_sb, a_rs, a_s64, a_xs, a_abort, a_fault, a_fc};
    assign vec_b = {b_irw, b_npc, b_regw, b_memw, b_fpuw, b_br, b_aluop, b_adr,
                    b_sa, b_sb, b_rs, b_s64, b_xs, b_abort, b_fault, b_fc};

    task automatic check_output(input string tag, input logic [20:0] observed,
                                input logic [20:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Waits for the falling edge, drives a full input set, then lets outputs settle.
    task automatic apply_stimulus(input logic [1:0] op, input logic [5:0] funct,
                                  input logic xop, input logic [1:0] id,
                                  input logic wide, input logic cex,
                                  input logic [1:0] done);
        @(negedge clk);
        Op      = op;
        Funct   = funct;
        xu_op   = xop;
        xu_id   = id;
        xu_wide = wide;
        cond_ex = cex;
        xu_done = done;
        #1;
    endtask

    task automatic hold(input logic [1:0] done);
        @(negedge clk);
        xu_done = done;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        Op      = 2'b00;
        Funct   = 6'b0;
        xu_op   = 1'b0;
        xu_id   = 2'd0;
        xu_wide = 1'b0;
        cond_ex = 1'b1;
        xu_done = 2'b00;

        apply_stimulus(2'b00, 6'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b11);
        check_output("reset_a", vec_a, E_ZERO);
        check_output("reset_b", vec_b, E_ZERO);
        release_reset();

        // LDR
        apply_stimulus(2'b01, 6'b000001, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        check_output("ldr_fetch_a", vec_a, E_FETCH);
        check_output("ldr_fetch_b", vec_b, E_FETCH);
        hold(2'b00); check_output("ldr_decode", vec_a, E_DECODE);
        hold(2'b00); check_output("ldr_memadr", vec_a, E_MEMADR);
        hold(2'b00); check_output("ldr_memread", vec_a, E_MEMREAD);
        hold(2'b00); check_output("ldr_memwb", vec_a, E_MEMWB);

        // STR
        apply_stimulus(2'b01, 6'b000000, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        check_output("str_fetch", vec_a, E_FETCH);
        hold(2'b00); check_output("str_decode", vec_a, E_DECODE);
        hold(2'b00); check_output("str_memadr", vec_a, E_MEMADR);
        hold(2'b00); check_output("str_memwrite", vec_a, E_MEMWRITE);

        // Data processing, register then immediate operand
        apply_stimulus(2'b00, 6'b000000, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        check_output("dpr_fetch", vec_a, E_FETCH);
        hold(2'b00); check_output("dpr_decode", vec_a, E_DECODE);
        hold(2'b00); check_output("dpr_executer", vec_a, E_EXECR);
        hold(2'b00); check_output("dpr_aluwb", vec_a, E_ALUWB);
        apply_stimulus(2'b00, 6'b100000, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        check_output("dpi_fetch", vec_a, E_FETCH);
        hold(2'b00); check_output("dpi_decode", vec_a, E_DECODE);
        hold(2'b00); check_output("dpi_executei", vec_a, E_EXECI);
        hold(2'b00); check_output("dpi_aluwb", vec_a, E_ALUWB);

        // Branch
        apply_stimulus(2'b10, 6'b000000, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        check_output("br_fetch", vec_a, E_FETCH);
        hold(2'b00); check_output("br_decode", vec_a, E_DECODE);
        hold(2'b00); check_output("br_branch", vec_a, E_BRANCH);

        // Illegal Op
        apply_stimulus(2'b11, 6'b000000, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        check_output("ill_fetch", vec_a, E_FETCH);
        hold(2'b00); check_output("ill_decode", vec_a, E_DECODE);
        hold(2'b00);
        check_output("ill_fault_a", vec_a, E_FAULT_ILL);
        check_output("ill_fault_b", vec_b, E_FAULT_ILL);

        // XU op with failed condition goes straight back to FETCH
        apply_stimulus(2'b00, 6'b000000, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00);
        check_output("cf_fetch", vec_a, E_FETCH);
        hold(2'b00); check_output("cf_decode", vec_a, E_DECODE);

        // Out-of-range unit index
        apply_stimulus(2'b00, 6'b000000, 1'b1, 2'd2, 1'b0, 1'b1, 2'b00);
        check_output("cf_back_to_fetch", vec_a, E_FETCH);
        hold(2'b00); check_output("badid_decode", vec_a, E_DECODE);
        hold(2'b00); check_output("badid_fault", vec_a, E_FAULT_ID);

        // FPU op, zero-wait done; done[0] noise must be ignored
        apply_stimulus(2'b00, 6'b000000, 1'b1, 2'd1, 1'b0, 1'b1, 2'b01);
        check_output("fpu_fetch", vec_a, E_FETCH);
        hold(2'b00); check_output("fpu_decode", vec_a, E_DECODE);
        hold(2'b11); check_output("fpu_xstart", vec_a, E_XSTART1);
        hold(2'b01); check_output("fpu_xwb", vec_a, E_XWB_FPU);

        // Timeout on unit 0: instance b aborts on its 3rd wait, a keeps waiting
        apply_stimulus(2'b00, 6'b000000, 1'b1, 2'd0, 1'b0, 1'b1, 2'b00);
        check_output("tmo_fetch", vec_b, E_FETCH);
        hold(2'b00); check_output("tmo_decode", vec_b, E_DECODE);
        hold(2'b00); check_output("tmo_xstart", vec_b, E_XSTART0);
        hold(2'b00); check_output("tmo_wait1", vec_b, E_XWAIT);
        hold(2'b10); check_output("tmo_wait2_other_done", vec_b, E_XWAIT);
        hold(2'b00);
        check_output("tmo_wait3_abort_b", vec_b, E_XABORT);
        check_output("tmo_wait3_a", vec_a, E_XWAIT);
        hold(2'b00);
        check_output("tmo_fault_b", vec_b, E_FAULT_TMO);
        check_output("tmo_wait4_a", vec_a, E_XWAIT);
        hold(2'b00); check_output("tmo_wait5_a", vec_a, E_XWAIT);

        // Reset in the middle of instance a's wait: no abort, all outputs low
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("midwait_reset_a", vec_a, E_ZERO);
        check_output("midwait_reset_b", vec_b, E_ZERO);
        release_reset();

        // Done lands in the same cycle the watchdog hits: done wins
        apply_stimulus(2'b00, 6'b000000, 1'b1, 2'd0, 1'b0, 1'b1, 2'b00);
        check_output("race_fetch_a", vec_a, E_FETCH);
        check_output("race_fetch_b", vec_b, E_FETCH);
        hold(2'b00); check_output("race_decode", vec_b, E_DECODE);
        hold(2'b00); check_output("race_xstart", vec_b, E_XSTART0);
        hold(2'b00); check_output("race_wait1", vec_b, E_XWAIT);
        hold(2'b00); check_output("race_wait2", vec_b, E_XWAIT);
        hold(2'b01); check_output("race_wait3_no_abort", vec_b, E_XWAIT);
        hold(2'b00); check_output("race_xwb", vec_b, E_XWB_REG);

        // UMULL on instance a: 5 wait cycles, then two write-back beats
        apply_stimulus(2'b00, 6'b000000, 1'b1, 2'd0, 1'b1, 1'b1, 2'b00);
        check_output("umull_fetch", vec_a, E_FETCH);
        hold(2'b00); check_output("umull_decode", vec_a, E_DECODE);
        hold(2'b00); check_output("umull_xstart", vec_a, E_XSTART0);
        for (int i = 1; i <= 4; i++) begin
            hold(2'b00);
            check_output($sformatf("umull_wait%0d", i), vec_a, E_XWAIT);
        end
        hold(2'b01); check_output("umull_wait5", vec_a, E_XWAIT);
        hold(2'b00); check_output("umull_xwb", vec_a, E_XWB_REG);
        hold(2'b00); check_output("umull_xwb_hi", vec_a, E_XWBHI_REG);
        hold(2'b00); check_output("umull_back_fetch", vec_a, E_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
